// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/2-write register file with issue scoreboard; index 0 is hardwired to zero.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data (and cleared busy) to the read ports.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic              stall,
    output logic              wr_conflict
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              r_wr_conflict;
    logic [ADDR_W-1:0] w_ra [2];
    logic [DATA_W-1:0] w_rd [2];
    logic              w_rb [2];

    // Writes clear first so a same-cycle issue to that index wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (we0) w_busy_nxt[wa0] = 1'b0;
        if (we1) w_busy_nxt[wa1] = 1'b0;
        if (iss_valid) w_busy_nxt[iss_dst] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_busy        <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            if (we0 && wa0 != '0) r_regs[wa0] <= wd0;
            if (we1 && wa1 != '0) r_regs[wa1] <= wd1;
            r_busy        <= w_busy_nxt;
            r_wr_conflict <= we0 && we1 && wa0 == wa1 && wa0 != '0;
        end
    end

    assign w_ra[0] = rs;
    assign w_ra[1] = rt;

    for (genvar p = 0; p < 2; p++) begin : g_rd
`ifdef REGFILE_SB_BYPASS_EN
        logic w_hit0, w_hit1, w_iss;
        assign w_hit0  = rst_n && we0 && wa0 == w_ra[p] && w_ra[p] != '0;
        assign w_hit1  = rst_n && we1 && wa1 == w_ra[p] && w_ra[p] != '0;
        assign w_iss   = iss_valid && iss_dst == w_ra[p];
        assign w_rd[p] = w_hit1 ? wd1 : w_hit0 ? wd0 : r_regs[w_ra[p]];
        assign w_rb[p] = ((w_hit0 || w_hit1) && !w_iss) ? 1'b0 : r_busy[w_ra[p]];
`else
        assign w_rd[p] = r_regs[w_ra[p]];
        assign w_rb[p] = r_busy[w_ra[p]];
`endif
    end

    assign rs_data     = w_rd[0];
    assign rt_data     = w_rd[1];
    assign busy_rs     = w_rb[0];
    assign busy_rt     = w_rb[1];
    assign stall       = busy_rs | busy_rt;
    assign wr_conflict = r_wr_conflict;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus random stimulus against an array-based reference model of regfile_sb.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;
`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] rs, rt, wa0, wa1, iss_dst;
    logic [DW-1:0] wd0, wd1, rs_data, rt_data;
    logic          we0, we1, iss_valid, busy_rs, busy_rt, stall, wr_conflict;

    logic [2:0]  p_rs, p_rt, p_wa0, p_wa1, p_dst;
    logic [15:0] p_wd0, p_wd1, p_rsd, p_rtd;
    logic        p_we0, p_we1, p_iss, p_brs, p_brt, p_stall, p_wc;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rs_data(rs_data), .rt_data(rt_data),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .busy_rs(busy_rs), .busy_rt(busy_rt),
        .stall(stall), .wr_conflict(wr_conflict)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut_p (
        .clk(clk), .rst_n(rst_n), .rs(p_rs), .rt(p_rt), .rs_data(p_rsd), .rt_data(p_rtd),
        .we0(p_we0), .we1(p_we1), .wa0(p_wa0), .wa1(p_wa1), .wd0(p_wd0), .wd1(p_wd1),
        .iss_valid(p_iss), .iss_dst(p_dst), .busy_rs(p_brs), .busy_rt(p_brt),
        .stall(p_stall), .wr_conflict(p_wc)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_regs [N];
    logic          m_busy [N];
    logic          m_conf;
    logic [15:0]   p_model [8];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clr();
        for (int i = 0; i < N; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    function automatic logic hit(input logic [AW-1:0] a);
        return BYP && rst_n && a != 0 && ((we0 && wa0 == a) || (we1 && wa1 == a));
    endfunction

    function automatic logic [DW-1:0] e_rd(input logic [AW-1:0] a);
        if (!rst_n || a == 0) return '0;
        if (hit(a)) return (we1 && wa1 == a) ? wd1 : wd0;
        return m_regs[a];
    endfunction

    function automatic logic e_busy(input logic [AW-1:0] a);
        if (!rst_n || a == 0) return 1'b0;
        if (hit(a) && !(iss_valid && iss_dst == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_all();
        chk("rs_data", rs_data, e_rd(rs));
        chk("rt_data", rt_data, e_rd(rt));
        chk("busy_rs", 32'(busy_rs), 32'(e_busy(rs)));
        chk("busy_rt", 32'(busy_rt), 32'(e_busy(rt)));
        chk("stall", 32'(stall), 32'(e_busy(rs) | e_busy(rt)));
        chk("wr_conflict", 32'(wr_conflict), 32'(rst_n && m_conf));
    endtask

    task automatic model_update();
        if (we0 && wa0 != 0) m_regs[wa0] = wd0;
        if (we1 && wa1 != 0) m_regs[wa1] = wd1;
        if (we0) m_busy[wa0] = 1'b0;
        if (we1) m_busy[wa1] = 1'b0;
        if (iss_valid && iss_dst != 0) m_busy[iss_dst] = 1'b1;
        m_conf = we0 && we1 && wa0 == wa1 && wa0 != 0;
    endtask

    task automatic step();
        #1 check_all();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic set_in(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input logic iv, input logic [AW-1:0] dst,
                          input logic [AW-1:0] r_s, input logic [AW-1:0] r_t);
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        iss_valid = iv; iss_dst = dst;
        rs = r_s; rt = r_t;
    endtask

    function automatic logic [AW-1:0] ra();
        return ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        {p_we0, p_we1, p_iss} = '0;
        {p_wa0, p_wa1, p_dst, p_rs, p_rt} = '0;
        {p_wd0, p_wd1} = '0;
        model_clr();
        repeat (2) @(negedge clk);
        set_in(1, 5, 32'h12345678, 1, 6, 32'h9, 1, 5, 5, 6);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 5, $urandom, 1, 6, $urandom, 1, 8, 5, 6);
            step();
        end
        set_in(1, 5, $urandom, 1, 5, $urandom, 1, 5, 5, 8);
        rst_n = 1'b0;
        model_clr();
        #1 chk("rst_rs5", rs_data, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        set_in(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("r0_after_write", rs_data, 32'h0);
        step();

        set_in(1, 3, 32'h11111111, 1, 4, 32'h22222222, 0, 0, 3, 4);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        #1 chk("dual_r3", rs_data, 32'h11111111);
        chk("dual_r4", rt_data, 32'h22222222);
        chk("dual_noconf", 32'(wr_conflict), 32'h0);
        step();

        set_in(1, 7, 32'hAAAAAAAA, 1, 7, 32'hBBBBBBBB, 0, 0, 7, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        #1 chk("conf_r7", rs_data, 32'hBBBBBBBB);
        chk("conf_flag", 32'(wr_conflict), 32'h1);
        step();
        #1 chk("conf_drop", 32'(wr_conflict), 32'h0);
        step();

        set_in(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        #1 chk("sb_set", 32'(stall), 32'h1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        step();
        set_in(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        #1 chk("sb_clear", 32'(stall), 32'h0);
        step();
        set_in(1, 9, 32'h98, 0, 0, 0, 1, 9, 9, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        #1 chk("sb_setprio", 32'(busy_rt), 32'h1);
        step();

        set_in(0, 0, 0, 1, 12, 32'hCAFEBABE, 0, 0, 12, 0);
        #1 chk("bypass", rs_data, BYP ? 32'hCAFEBABE : 32'h0);
        step();

        set_in(1, 20, 32'hDEADBEEF, 0, 0, 0, 1, 20, 20, 0);
        #2 rst_n = 1'b0;
        model_clr();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 20, 12);
        #1 chk("midrst_data", rs_data, 32'h0);
        chk("midrst_busy", 32'(busy_rs), 32'h0);
        step();

        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom), ra(), $urandom, 1'($urandom), ra(), $urandom,
                   1'($urandom), ra(), ra(), ra());
            step();
        end

        for (int i = 0; i < 8; i++) p_model[i] = '0;
        p_we0 = 1'b1; p_wa0 = 3'd7; p_wd0 = 16'hA5C3;
        p_we1 = 1'b1; p_wa1 = 3'd0; p_wd1 = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        p_model[7] = 16'hA5C3;
        p_we0 = 1'b0; p_we1 = 1'b0; p_rs = 3'd7; p_rt = 3'd0;
        #1 chk("p_r7", 32'(p_rsd), 32'hA5C3);
        chk("p_r0", 32'(p_rtd), 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            p_we0 = 1'b1; p_wa0 = 3'($urandom_range(1, 7)); p_wd0 = 16'($urandom);
            @(posedge clk);
            p_model[p_wa0] = p_wd0;
            @(negedge clk);
            p_we0 = 1'b0; p_rs = 3'($urandom_range(0, 7)); p_rt = p_wa0;
            #1 chk("p_rs", 32'(p_rsd), 32'(p_model[p_rs]));
            chk("p_rt", 32'(p_rtd), 32'(p_model[p_rt]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rs, rt  input  ADDR_W each  read-port register indices.
REQ-006 SHALL have ports rs_data, rt_data  output  DATA_W each  read data.
REQ-007 SHALL have ports we0, we1  input  1 each  write enables, port 0 and port 1.
REQ-008 SHALL have ports wa0, wa1  input  ADDR_W each  write indices.
REQ-009 SHALL have ports wd0, wd1  input  DATA_W each  write data.
REQ-010 SHALL have port iss_valid  input  1  instruction issue strobe; marks iss_dst pending.
REQ-011 SHALL have port iss_dst  input  ADDR_W  destination of issued instruction.
REQ-012 SHALL have ports busy_rs, busy_rt  output  1 each  source register has pending write.
REQ-013 SHALL have port stall  output  1  busy_rs OR busy_rt.
REQ-014 SHALL have port wr_conflict  output  1  registered one-cycle flag: both ports wrote the same register.

Function
REQ-015 SHALL read combinationally; index 0 always reads 0 and always reports not busy.
REQ-016 SHALL ignore writes to index 0 and issues with iss_dst 0.
REQ-017 SHALL write wd0 to wa0 when we0, and wd1 to wa1 when we1, at the clock edge; both may write in one cycle.
REQ-018 SHALL, when we0 and we1 both target the same nonzero index, store wd1 (port 1 wins) and assert wr_conflict for exactly the following cycle.
REQ-019 SHALL keep busy[DEPTH-1:0]: iss_valid sets busy[iss_dst]; a write on either port clears busy[wa] at the same edge.
REQ-020 SHALL give set priority when iss_valid and a write target the same index in one cycle: busy ends 1.
REQ-021 SHALL leave busy unchanged by an issue to an already-busy register (no counting; one write clears it).
REQ-022 SHALL drive busy_rs = busy[rs], busy_rt = busy[rt], stall = busy_rs | busy_rt, combinationally.
REQ-023 SHALL not block writes or issues while stall is high; stall is advisory to the issuing pipeline.

Reset
REQ-024 SHALL, while rst_n is low, asynchronously clear all registers to 0, all busy bits to 0, and wr_conflict to 0.
REQ-025 SHALL therefore drive rs_data = rt_data = 0 and busy_rs = busy_rt = stall = 0 during reset, ignoring all write and issue inputs.
REQ-026 SHALL resume normal operation at the first rising clk edge after rst_n deasserts; reset mid-write discards that write.

Configuration
REQ-027 SHALL implement same-cycle write bypass only when macro REGFILE_SB_BYPASS_EN is defined.
REQ-028 SHALL, with REGFILE_SB_BYPASS_EN: on a read index equal to an active nonzero write index, return that write data (wd1 over wd0) and force the matching busy output to 0, unless iss_valid targets the same index that cycle.
REQ-029 SHALL, without REGFILE_SB_BYPASS_EN: return only stored contents; busy outputs reflect stored busy bits; written data is visible the cycle after the write.

Verification
REQ-030 SHALL check reset: rst_n=0 after arbitrary writes -> rs=5 reads 0, stall=0; rs=0 with we0=1 wa0=0 wd0=FFFFFFFF -> rs_data=0 next cycle.
REQ-031 SHALL check dual write: we0 wa0=3 wd0=11111111, we1 wa1=4 wd1=22222222 -> next cycle reg3=11111111, reg4=22222222, wr_conflict=0.
REQ-032 SHALL check conflict: we0 wa0=7 wd0=AAAAAAAA, we1 wa1=7 wd1=BBBBBBBB -> reg7=BBBBBBBB, wr_conflict=1 one cycle, then 0.
REQ-033 SHALL check scoreboard: iss_valid iss_dst=9, next cycle rs=9 -> stall=1; we0 wa0=9 -> stall=0 after edge; same-cycle issue+write to 9 -> busy stays 1.
REQ-034 SHALL check bypass: we1 wa1=12 wd1=CAFEBABE, rs=12 same cycle -> rs_data=CAFEBABE with REGFILE_SB_BYPASS_EN, old value (0 after reset) without.
REQ-035 SHALL check parameters: DATA_W=16, ADDR_W=3 -> writes to index 7 read back 16-bit value, index 0 reads 0.
